// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default sizing for the PWM fade controller and its helpers.
package pwm_ctrl_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RAMP = 1'b1
  } fade_state_t;

  localparam int DEF_N        = 8;
  localparam int DEF_STEP_DIV = 16;
  localparam int DEF_R        = 8;

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// Request handshake and PWM-facing outputs of the fade controller.
interface pwm_fade_ctrl_if
  import pwm_ctrl_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int R = DEF_R
);

  logic         ena;
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_target;
  logic [R-1:0] req_rate;
  logic         abort;
  logic         step;
  logic [N-1:0] duty;
  logic         pwm_ena;
  logic         busy;
  logic         done;

  modport master (
    output ena, req_valid, req_target, req_rate, abort,
    input  req_ready, step, duty, pwm_ena, busy, done
  );

  modport slave (
    input  ena, req_valid, req_target, req_rate, abort,
    output req_ready, step, duty, pwm_ena, busy, done
  );

endinterface

// File: rtl/step_divider.sv
// Free-running prescaler producing a one-cycle step pulse every STEP_DIV enabled cycles.
module step_divider #(
  parameter int STEP_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  output logic step
);

  localparam int           W    = $clog2(STEP_DIV);
  localparam logic [W-1:0] LAST = W'(STEP_DIV - 1);

  logic [W-1:0] div_cnt_q;
  logic [W-1:0] div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (ena) begin
      if (div_cnt_q == LAST) begin
        div_cnt_d = {W{1'b0}};
      end else begin
        div_cnt_d = div_cnt_q + W'(1);
      end
    end else begin
      div_cnt_d = div_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= {W{1'b0}};
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign step = ena & (div_cnt_q == LAST);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Walks the PWM duty one LSB per (rate+1) step pulses toward a requested target.
module pwm_fade_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int STEP_DIV = DEF_STEP_DIV,
  parameter int R        = DEF_R
) (
  input logic             clk,
  input logic             rst,
  pwm_fade_ctrl_if.slave  bus
);

  fade_state_t  state_q, state_d;
  logic [N-1:0] duty_q, duty_d;
  logic [N-1:0] target_q, target_d;
  logic [R-1:0] rate_q, rate_d;
  logic [R-1:0] rate_cnt_q, rate_cnt_d;
  logic         done_q, done_d;
  logic         step_s;
  logic [N-1:0] duty_mv_s;

  step_divider #(.STEP_DIV(STEP_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .ena  (bus.ena),
    .step (step_s)
  );

  // Duty only ever moves toward the target, so neither direction can wrap.
  assign duty_mv_s = (duty_q < target_q) ? (duty_q + N'(1)) : (duty_q - N'(1));

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    rate_d     = rate_q;
    rate_cnt_d = rate_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ena && bus.req_valid) begin
          target_d   = bus.req_target;
          rate_d     = bus.req_rate;
          rate_cnt_d = {R{1'b0}};
          if (bus.req_target != duty_q) begin
            state_d = S_RAMP;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RAMP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (step_s) begin
          if (rate_cnt_q == rate_q) begin
            rate_cnt_d = {R{1'b0}};
            duty_d     = duty_mv_s;
            if (duty_mv_s == target_q) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RAMP;
            end
          end else begin
            rate_cnt_d = rate_cnt_q + R'(1);
          end
        end else begin
          state_d = S_RAMP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      duty_q     <= {N{1'b0}};
      target_q   <= {N{1'b0}};
      rate_q     <= {R{1'b0}};
      rate_cnt_q <= {R{1'b0}};
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      rate_q     <= rate_d;
      rate_cnt_q <= rate_cnt_d;
      done_q     <= done_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE) & bus.ena;
  assign bus.step      = step_s;
  assign bus.duty      = duty_q;
  assign bus.pwm_ena   = bus.ena;
  assign bus.busy      = (state_q == S_RAMP);
  assign bus.done      = done_q;

endmodule

// File: doc/pwm_fade_ctrl.md
# pwm_fade_ctrl

Sequencing controller for the `pwm` block. It generates the `step` enable that paces the PWM counter, and it owns the `duty` input. A requester issues a target duty and a ramp rate through a valid/ready handshake; the controller walks `duty` one LSB at a time toward the target, paced by the step pulses, then reports completion. It sits between a user-facing front end (buttons, UART, sketch logic) and one `pwm` instance.

## Interface
Parameters:
- `N`, 8, duty width; must match the driven `pwm` instance.
- `STEP_DIV`, 16, clk cycles per `step` pulse; must be ≥ 2.
- `R`, 8, width of the ramp-rate field.

Ports:
- `clk` in 1: single clock; all state changes on posedge.
- `rst` in 1: **asynchronous, active-low** reset.
- `ena` in 1: global enable.
  - Low freezes the prescaler, the ramp and `step`.
  - Passed through to `pwm_ena`.
- `req_valid` in 1: a ramp request is presented.
- `req_ready` out 1: the controller can accept a request.
- `req_target` in N: target duty.
- `req_rate` in R: extra step pulses between duty updates. 0 means one update per step pulse.
- `abort` in 1: cancel the active ramp.
- `step` out 1: one-cycle pulse into `pwm.step`.
- `duty` out N: registered duty into `pwm.duty`.
- `pwm_ena` out 1: into `pwm.ena`; equals `ena`.
- `busy` out 1: a ramp is in progress.
- `done` out 1: one-cycle pulse when a ramp reaches its target.

## Operation
- **States:** IDLE and RAMP.
- **Prescaler** (`div_cnt`, width `$clog2(STEP_DIV)`):
  - Increments when `ena` is high.
  - Wraps from `STEP_DIV-1` to 0.
  - `step = ena & (div_cnt == STEP_DIV-1)`, combinational.
  - Runs in both states.
- **Handshake:**
  - `req_ready = (state == IDLE) & ena`.
  - A transfer occurs on a posedge where `req_valid & req_ready` is high.
  - On transfer: latch `target <= req_target` and `rate <= req_rate`, and clear `rate_cnt`.
  - If `req_target != duty`: go to RAMP.
  - If `req_target == duty`: stay in IDLE and assert `done` the next cycle. `duty` is unchanged.
- **RAMP**, on each cycle with `step` high:
  - If `rate_cnt == rate`:
    - `rate_cnt <= 0`.
    - `duty <= duty + 1` if `duty < target`, else `duty - 1`.
    - If the new duty equals `target`: go to IDLE and set `done <= 1`.
  - Otherwise `rate_cnt <= rate_cnt + 1`.
- **Duty arithmetic:** unsigned, N bits. Duty moves strictly toward the target, so it never wraps past 0 or 2^N-1.
- **`abort` in RAMP:** go to IDLE next cycle. `duty` holds its current value; `done` is not asserted.
  - `abort` has priority over a simultaneous duty update; that update is dropped.
  - `abort` in IDLE is ignored.
- **`ena` low:**
  - `step = 0`, `req_ready = 0`.
  - Prescaler, `rate_cnt` and `duty` hold; state holds.
  - `abort` is still honored.
- **`busy`:** `(state == RAMP)`.

## Timing
- **Reset values** (asynchronous, immediate on `rst` low):
  - `state` IDLE; `duty` 0; `div_cnt` 0; `rate_cnt` 0; `target` 0; `done` 0; `busy` 0; `step` 0.
  - `req_ready` follows `ena`; `pwm_ena` follows `ena`.
- **Reset mid-ramp:** `duty` drops to 0 without `done`. Release is synchronous to `clk`, through an external synchronizer.
- **Acceptance latency:** `busy` rises 1 cycle after the accepting edge.
- **Step spacing:** with `ena` held high, pulses are exactly `STEP_DIV` cycles apart.
- **Duty update spacing:** one update per `(rate+1)` step pulses, i.e. `(rate+1)*STEP_DIV` cycles.
- **Completion:** `done` and `duty == target` become visible in the same cycle. `req_ready` is high that same cycle, so back-to-back requests are legal.
- **Ramp length:** exactly `|target - duty_start|` updates.

## Structure
- **Package `pwm_ctrl_pkg`:**
  - `typedef enum logic {S_IDLE, S_RAMP} fade_state_t`.
  - Default constants for `N` and `STEP_DIV`.
- **Sub-module `step_divider`:**
  - Parameter `STEP_DIV`.
  - Ports `clk`, `rst`, `ena`, `step`.
  - Reused by other front-end blocks.
- **Top-level:** the FSM, `rate_cnt` and the duty register, with sequential and combinational logic kept in separate blocks.

## Test plan
Benches use N=8, STEP_DIV=4, R=4.
- Reset, then hold `ena` low for 10 cycles → `duty` 0, `step` 0, `busy` 0, `req_ready` 0.
- `ena`=1, request target 3, rate 0 → `duty` steps 1, 2, 3 on successive step pulses 4 cycles apart; `done` pulses once with `duty`=3; `busy` falls in the same cycle.
- From `duty`=3, request target 0, rate 1 → 3 decrements spaced 8 cycles apart; `done` after the 6th step pulse.
- Request target 200, then assert `abort` after 5 updates → `duty` holds at 5, no `done`, `req_ready` 1 on the next cycle. Then request target 5 → `done` the next cycle with no duty change.
- Mid-ramp, drop `ena` for 9 cycles → `step`, `duty` and `div_cnt` freeze; on re-enable the ramp resumes with identical spacing.
- Assert `rst` low mid-ramp, between clock edges → `duty`=0, `busy`=0 immediately; no `done`.
